// File: rtl/computer_system_sysinfo_pkg.sv
// Shared constants for the system-information slave: register word map,
// CONTROL bit positions, word-2 field layout and a byte-lane merge helper.
package computer_system_sysinfo_pkg;

  localparam logic [3:0] ADDR_SYSID     = 4'd0;
  localparam logic [3:0] ADDR_TSTAMP    = 4'd1;
  localparam logic [3:0] ADDR_VERSION   = 4'd2;
  localparam logic [3:0] ADDR_UPTIME_LO = 4'd3;
  localparam logic [3:0] ADDR_SHADOW    = 4'd4;
  localparam logic [3:0] ADDR_CONTROL   = 4'd5;
  localparam logic [3:0] ADDR_PRESCALE  = 4'd6;
  localparam logic [3:0] ADDR_SCRATCH0  = 4'd8;

  localparam int CTRL_FREEZE = 0;
  localparam int CTRL_CLEAR  = 1;

  localparam int W2_VERSION_LSB = 16;
  localparam int W2_NSCR_LSB    = 8;

  function automatic logic [31:0] be_merge(input logic [31:0] cur,
                                           input logic [31:0] wd,
                                           input logic [3:0]  be);
    logic [31:0] res;
    res = cur;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) res[8*b +: 8] = wd[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/computer_system_sysinfo_if.sv
// Lightweight Avalon-MM slave bundle for the system-information block.
interface computer_system_sysinfo_if;
  logic [3:0]  address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic [31:0] readdata;
  logic        readdatavalid;

  modport master (
    output address, read, write, writedata, byteenable,
    input  readdata, readdatavalid
  );

  modport slave (
    input  address, read, write, writedata, byteenable,
    output readdata, readdatavalid
  );
endinterface

// File: rtl/computer_system_sysinfo_uptime.sv
// Microsecond-style uptime: a prescaler dividing the clock into ticks that
// advance a 64-bit free-running counter; freeze holds both, clear zeroes both.
module computer_system_sysinfo_uptime #(
  parameter int PRESCALE = 50
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        freeze,
  input  logic        clear,
  output logic        tick,
  output logic [63:0] count
);

  localparam logic [15:0] PRE_LAST = 16'(PRESCALE - 1);

  logic [15:0] r_pre;
  logic [63:0] r_count;
  logic        r_tick;

  // Clear outranks both freeze and a due tick, so no pulse escapes a clear.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_pre   <= '0;
      r_count <= '0;
      r_tick  <= 1'b0;
    end else if (clear) begin
      r_pre   <= '0;
      r_count <= '0;
      r_tick  <= 1'b0;
    end else if (freeze) begin
      r_tick  <= 1'b0;
    end else if (r_pre == PRE_LAST) begin
      r_pre   <= '0;
      r_count <= r_count + 64'd1;
      r_tick  <= 1'b1;
    end else begin
      r_pre   <= r_pre + 16'd1;
      r_tick  <= 1'b0;
    end
  end

  assign tick  = r_tick;
  assign count = r_count;

endmodule

// File: rtl/computer_system_sysinfo.sv
// System-information register block: build identity, uptime with a high-word
// shadow, CONTROL (freeze/clear) and a small scratch array on an Avalon-MM slave.
module computer_system_sysinfo
  import computer_system_sysinfo_pkg::*;
#(
  parameter logic [31:0] SYSTEM_ID     = 32'h0000_0000,
  parameter logic [31:0] TIMESTAMP     = 32'h0000_0000,
  parameter logic [15:0] VERSION       = 16'h0001,
  parameter int          PRESCALE      = 50,
  parameter int          NUM_SCRATCH   = 4,
  parameter logic [31:0] SCRATCH_RESET = 32'h0000_0000
) (
  input  logic                     clock,
  input  logic                     reset_n,
  computer_system_sysinfo_if.slave bus,
  output logic                     tick_out
);

  logic        w_rd;
  logic        w_wr;
  logic        w_ctrl_wr;
  logic        w_clear;
  logic        w_scr_hit;
  logic [2:0]  w_scr_idx;
  logic [63:0] w_count;
  logic [31:0] w_scr_rd;
  logic [31:0] w_rdata;

  logic        r_freeze;
  logic        r_rvld;
  logic [31:0] r_rdata;
  logic [31:0] r_shadow;
  logic [31:0] r_scratch [NUM_SCRATCH];

  // A write colliding with a read is dropped; the read wins.
  assign w_rd      = bus.read;
  assign w_wr      = bus.write & ~bus.read;
  assign w_ctrl_wr = w_wr & (bus.address == ADDR_CONTROL) & bus.byteenable[0];
  assign w_clear   = w_ctrl_wr & bus.writedata[CTRL_CLEAR];
  assign w_scr_idx = bus.address[2:0];
  assign w_scr_hit = bus.address[3] & ({1'b0, w_scr_idx} < 4'(NUM_SCRATCH));

  computer_system_sysinfo_uptime #(
    .PRESCALE (PRESCALE)
  ) u_uptime (
    .clock   (clock),
    .reset_n (reset_n),
    .freeze  (r_freeze),
    .clear   (w_clear),
    .tick    (tick_out),
    .count   (w_count)
  );

  always_comb begin
    w_scr_rd = '0;
    for (int i = 0; i < NUM_SCRATCH; i++) begin
      if (w_scr_idx == 3'(i)) w_scr_rd = r_scratch[i];
    end
  end

  always_comb begin
    w_rdata = '0;
    case (bus.address)
      ADDR_SYSID:     w_rdata = SYSTEM_ID;
      ADDR_TSTAMP:    w_rdata = TIMESTAMP;
      ADDR_VERSION: begin
        w_rdata[W2_VERSION_LSB +: 16] = VERSION;
        w_rdata[W2_NSCR_LSB +: 8]     = 8'(NUM_SCRATCH);
      end
      ADDR_UPTIME_LO: w_rdata = w_count[31:0];
      ADDR_SHADOW:    w_rdata = r_shadow;
      ADDR_CONTROL:   w_rdata[CTRL_FREEZE] = r_freeze;
      ADDR_PRESCALE:  w_rdata[15:0] = 16'(PRESCALE);
      default:        if (w_scr_hit) w_rdata = w_scr_rd;
    endcase
  end

  // Shadow latches the high word on the same edge the low word is returned,
  // so a low/high pair always comes from one counter snapshot.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_rvld   <= 1'b0;
      r_rdata  <= '0;
      r_shadow <= '0;
    end else begin
      r_rvld <= w_rd;
      if (w_rd) begin
        r_rdata <= w_rdata;
        if (bus.address == ADDR_UPTIME_LO) r_shadow <= w_count[63:32];
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_freeze <= 1'b0;
    end else if (w_ctrl_wr) begin
      r_freeze <= bus.writedata[CTRL_FREEZE];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_SCRATCH; i++) r_scratch[i] <= SCRATCH_RESET;
    end else begin
      for (int i = 0; i < NUM_SCRATCH; i++) begin
        if (w_wr && w_scr_hit && (w_scr_idx == 3'(i)))
          r_scratch[i] <= be_merge(r_scratch[i], bus.writedata, bus.byteenable);
      end
    end
  end

  assign bus.readdata      = r_rdata;
  assign bus.readdatavalid = r_rvld;

endmodule

// File: tb/tb_computer_system_sysinfo.sv
// Bench for the system-information block: a behavioural register/uptime model
// checked every cycle, plus directed reads with hand-computed values.
module tb_computer_system_sysinfo;

  localparam int          P    = 4;
  localparam int          NS   = 4;
  localparam logic [31:0] SID  = 32'hC0DE_2024;
  localparam logic [31:0] TS   = 32'h6500_1234;
  localparam logic [15:0] VER  = 16'h0203;
  localparam logic [31:0] SRST = 32'hA5A5_0F0F;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic tick;
  logic tick0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  computer_system_sysinfo_if bus ();
  computer_system_sysinfo_if bus0 ();

  computer_system_sysinfo #(
    .SYSTEM_ID     (SID),
    .TIMESTAMP     (TS),
    .VERSION       (VER),
    .PRESCALE      (P),
    .NUM_SCRATCH   (NS),
    .SCRATCH_RESET (SRST)
  ) dut (
    .clock    (clk),
    .reset_n  (rst_n),
    .bus      (bus.slave),
    .tick_out (tick)
  );

  computer_system_sysinfo dut0 (
    .clock    (clk),
    .reset_n  (rst_n),
    .bus      (bus0.slave),
    .tick_out (tick0)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [63:0] m_up;
  logic [15:0] m_pre;
  logic        m_freeze, m_tick, m_rv;
  logic [31:0] m_rd, m_shadow;
  logic [31:0] m_scr [NS];
  logic        ld_en = 1'b0;
  logic [63:0] ld_up = '0;
  logic [15:0] ld_pre = '0;
  logic [63:0] cu;
  logic [15:0] cp;
  logic        m_wr, m_clr;

  assign cu    = ld_en ? ld_up : m_up;
  assign cp    = ld_en ? ld_pre : m_pre;
  assign m_wr  = bus.write && !bus.read;
  assign m_clr = m_wr && (bus.address == 4'd5) && bus.byteenable[0] && bus.writedata[1];

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] w, input logic [3:0] be);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = w[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] mword(input logic [3:0] a);
    case (a)
      4'd0: return SID;
      4'd1: return TS;
      4'd2: return {VER, 8'(NS), 8'h00};
      4'd3: return cu[31:0];
      4'd4: return m_shadow;
      4'd5: return {31'd0, m_freeze};
      4'd6: return 32'(P);
      4'd8, 4'd9, 4'd10, 4'd11: return m_scr[a[1:0]];
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_up <= '0; m_pre <= '0; m_freeze <= 1'b0; m_tick <= 1'b0;
      m_rv <= 1'b0; m_rd <= '0; m_shadow <= '0;
      for (int i = 0; i < NS; i++) m_scr[i] <= SRST;
    end else begin
      m_rv <= bus.read;
      if (bus.read) begin
        m_rd <= mword(bus.address);
        if (bus.address == 4'd3) m_shadow <= cu[63:32];
      end
      if (m_clr) begin
        m_up <= '0; m_pre <= '0; m_tick <= 1'b0;
      end else if (m_freeze) begin
        m_up <= cu; m_pre <= cp; m_tick <= 1'b0;
      end else if (int'(cp) == P - 1) begin
        m_up <= cu + 64'd1; m_pre <= '0; m_tick <= 1'b1;
      end else begin
        m_up <= cu; m_pre <= cp + 16'd1; m_tick <= 1'b0;
      end
      if (m_wr && bus.address == 4'd5 && bus.byteenable[0]) m_freeze <= bus.writedata[0];
      if (m_wr && bus.address >= 4'd8 && bus.address <= 4'd11)
        m_scr[bus.address[1:0]] <= merge(m_scr[bus.address[1:0]], bus.writedata, bus.byteenable);
    end
  end

  always @(negedge clk) begin
    chk("model_rdvalid", {63'd0, bus.readdatavalid}, {63'd0, m_rv});
    chk("model_rdata", {32'd0, bus.readdata}, {32'd0, m_rd});
    chk("model_tick", {63'd0, tick}, {63'd0, m_tick});
  end

  // ---------------- bus tasks ----------------
  task automatic rd(input logic [3:0] a, output logic [31:0] d);
    bus.address = a; bus.read = 1'b1;
    @(negedge clk);
    bus.read = 1'b0;
    d = bus.readdata;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
    bus.address = a; bus.writedata = d; bus.byteenable = be; bus.write = 1'b1;
    @(negedge clk);
    bus.write = 1'b0;
  endtask

  task automatic rd0(input logic [3:0] a, input logic [31:0] exp, input string nm);
    bus0.address = a; bus0.read = 1'b1;
    @(negedge clk);
    bus0.read = 1'b0;
    chk({nm, "_vld"}, {63'd0, bus0.readdatavalid}, 64'd1);
    chk({nm, "_data"}, {32'd0, bus0.readdata}, {32'd0, exp});
    @(negedge clk);
    chk({nm, "_vld_drop"}, {63'd0, bus0.readdatavalid}, 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int          nt;
    logic [31:0] d, v1;
    bus.address = '0; bus.read = 1'b0; bus.write = 1'b0; bus.writedata = '0; bus.byteenable = '0;
    bus0.address = '0; bus0.read = 1'b0; bus0.write = 1'b0; bus0.writedata = '0; bus0.byteenable = '0;
    nt = 0;
    #1 rst_n = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("rst_rdata", {32'd0, bus.readdata}, 64'd0);
    chk("rst_vld", {63'd0, bus.readdatavalid}, 64'd0);
    chk("rst_tick", {63'd0, tick}, 64'd0);
    rst_n = 1'b1;

    fork
      begin
        chk("dut0_idle_vld", {63'd0, bus0.readdatavalid}, 64'd0);
        rd0(4'd0, 32'h0000_0000, "dut0_sysid");
        rd0(4'd1, 32'h0000_0000, "dut0_tstamp");
        rd0(4'd2, 32'h0001_0400, "dut0_word2");
        rd0(4'd6, 32'd50, "dut0_prescale");
        chk("dut0_tick", {63'd0, tick0}, 64'd0);
      end
      begin
        repeat (40) begin
          @(negedge clk);
          if (tick) nt++;
        end
      end
    join
    rd(4'd3, d); chk("uptime_after_40", {32'd0, d}, 64'd10);
    chk("ticks_in_40", 64'(nt), 64'd10);
    rd(4'd4, d); chk("shadow_after_40", {32'd0, d}, 64'd0);
    rd(4'd8, d); chk("scratch_reset", {32'd0, d}, {32'd0, SRST});
    rd(4'd0, d); chk("sysid", {32'd0, d}, {32'd0, SID});
    rd(4'd2, d); chk("word2", {32'd0, d}, 64'h0000_0000_0203_0400);
    rd(4'd6, d); chk("prescale", {32'd0, d}, 64'd4);

    // low word at all-ones, prescaler due: carry lands on the read edge
    force dut.u_uptime.r_count = 64'h0000_0000_FFFF_FFFF;
    force dut.u_uptime.r_pre = 16'd3;
    ld_up = 64'h0000_0000_FFFF_FFFF; ld_pre = 16'd3; ld_en = 1'b1;
    #1;
    release dut.u_uptime.r_count;
    release dut.u_uptime.r_pre;
    rd(4'd3, d); ld_en = 1'b0;
    chk("carry_lo", {32'd0, d}, 64'h0000_0000_FFFF_FFFF);
    rd(4'd4, d); chk("carry_hi", {32'd0, d}, 64'd0);
    rd(4'd3, d); chk("post_carry_lo", {32'd0, d}, 64'd0);
    rd(4'd4, d); chk("post_carry_hi", {32'd0, d}, 64'd1);

    wr(4'd5, 32'd1, 4'hF);
    rd(4'd3, v1);
    nt = 0;
    repeat (100) begin
      @(negedge clk);
      if (tick) nt++;
    end
    chk("freeze_ticks", 64'(nt), 64'd0);
    rd(4'd3, d); chk("freeze_hold", {32'd0, d}, {32'd0, v1});
    rd(4'd5, d); chk("control_freeze", {32'd0, d}, 64'd1);
    wr(4'd5, 32'd0, 4'hF);
    begin : wait_due
      int k;
      k = 0;
      while (int'(m_pre) != P - 1 && k < 20) begin
        @(negedge clk);
        k++;
      end
      chk("tick_due_reached", {63'd0, (int'(m_pre) == P - 1)}, 64'd1);
    end
    wr(4'd5, 32'd2, 4'hF);
    chk("clear_no_tick", {63'd0, tick}, 64'd0);
    rd(4'd3, d); chk("clear_uptime", {32'd0, d}, 64'd0);
    rd(4'd5, d); chk("clear_reads0", {32'd0, d}, 64'd0);
    repeat (6) @(negedge clk);
    wr(4'd5, 32'd2, 4'b1110);
    repeat (3) @(negedge clk);

    wr(4'd8, 32'd0, 4'hF);
    wr(4'd8, 32'hDEAD_BEEF, 4'b0101);
    rd(4'd8, d); chk("scratch_be", {32'd0, d}, 64'h0000_0000_00AD_00EF);
    wr(4'd11, 32'h1234_5678, 4'hF);
    rd(4'd11, d); chk("scratch3", {32'd0, d}, 64'h0000_0000_1234_5678);
    wr(4'd15, 32'hFFFF_FFFF, 4'hF);
    rd(4'd15, d); chk("addr15", {32'd0, d}, 64'd0);
    rd(4'd12, d); chk("addr12", {32'd0, d}, 64'd0);

    bus.address = 4'd9; bus.writedata = 32'd0; bus.byteenable = 4'hF;
    bus.read = 1'b1; bus.write = 1'b1;
    @(negedge clk);
    bus.read = 1'b0; bus.write = 1'b0;
    chk("rw_read", {32'd0, bus.readdata}, {32'd0, SRST});
    rd(4'd9, d); chk("rw_write_dropped", {32'd0, d}, {32'd0, SRST});

    bus.address = 4'd0; bus.read = 1'b1;
    #2 rst_n = 1'b0;
    @(negedge clk);
    bus.read = 1'b0;
    chk("rst_mid_vld", {63'd0, bus.readdatavalid}, 64'd0);
    @(negedge clk);
    chk("rst_mid_vld2", {63'd0, bus.readdatavalid}, 64'd0);
    rst_n = 1'b1;
    rd(4'd8, d); chk("rst_scratch", {32'd0, d}, {32'd0, SRST});
    rd(4'd5, d); chk("rst_control", {32'd0, d}, 64'd0);
    rd(4'd4, d); chk("rst_shadow", {32'd0, d}, 64'd0);
    rd(4'd3, d); chk("rst_uptime", {32'd0, d}, 64'd0);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
